// File: rtl/rmw_long_latency_p_pkg.sv
// Shared types for the read-modify-write engine: command opcodes and per-entry lifecycle.
package rmw_long_latency_p_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_ADDI = 2'd1,
        OP_SUBI = 2'd2,
        OP_MOVI = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_WB
    } entry_state_t;

endpackage

// File: rtl/rmw_long_latency_p_if.sv
// Command, lookup, response and write-back bus of the read-modify-write engine.
interface rmw_long_latency_p_if
    import rmw_long_latency_p_pkg::*;
#(
    parameter int W     = 32,
    parameter int ID_W  = 16,
    parameter int TAG_W = 4
);
    logic             issue_vld;
    logic [ID_W-1:0]  issue_id;
    logic [W-1:0]     issue_imm;
    op_t              issue_op;
    logic             issue_rdy;
    logic             lk_vld;
    logic [TAG_W-1:0] lk_tag;
    logic [ID_W-1:0]  lk_id;
    logic             lk_rdy;
    logic             rsp_vld;
    logic [TAG_W-1:0] rsp_tag;
    logic [W-1:0]     rsp_word;
    logic             wr_vld;
    logic [ID_W-1:0]  wr_id;
    logic [W-1:0]     wr_word;
    logic             busy;

    modport master (
        output issue_vld, issue_id, issue_imm, issue_op, lk_rdy, rsp_vld, rsp_tag, rsp_word,
        input  issue_rdy, lk_vld, lk_tag, lk_id, wr_vld, wr_id, wr_word, busy
    );

    modport slave (
        input  issue_vld, issue_id, issue_imm, issue_op, lk_rdy, rsp_vld, rsp_tag, rsp_word,
        output issue_rdy, lk_vld, lk_tag, lk_id, wr_vld, wr_id, wr_word, busy
    );

endinterface

// File: rtl/rmw_long_latency_p_alloc.sv
// Picks the lowest-index idle entry for a new lookup.
module rmw_long_latency_p_alloc #(
    parameter int N     = 16,
    parameter int TAG_W = 4
) (
    input  logic [N-1:0]     idle,
    output logic             found,
    output logic [TAG_W-1:0] tag
);

    // Scanning downwards lets the lowest set bit win.
    always_comb begin
        found = 1'b0;
        tag   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (idle[i]) begin
                found = 1'b1;
                tag   = TAG_W'(i);
            end
        end
    end

endmodule

// File: rtl/rmw_long_latency_p.sv
// Read-modify-write engine with tagged, out-of-order lookups into a long-latency table.
// Define RMW_LONG_LATENCY_P_COALESCE_EN to fold same-id commands into a still-waiting lookup.
module rmw_long_latency_p
    import rmw_long_latency_p_pkg::*;
#(
    parameter int W           = 32,
    parameter int ID_W        = 16,
    parameter int IN_FLIGHT_N = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    rmw_long_latency_p_if.slave bus
);
    localparam int TAG_W = (IN_FLIGHT_N > 1) ? $clog2(IN_FLIGHT_N) : 1;

    typedef struct packed {
        logic         is_mov;
        logic [W-1:0] val;
    } acc_t;

    function automatic acc_t op_to_acc(input op_t op, input logic [W-1:0] imm);
        acc_t a;
        a.is_mov = (op == OP_MOVI);
        a.val    = (op == OP_SUBI) ? -imm : imm;
        return a;
    endfunction

    entry_state_t     state  [IN_FLIGHT_N];
    logic [ID_W-1:0]  ent_id [IN_FLIGHT_N];
    acc_t             acc    [IN_FLIGHT_N];
    logic [IN_FLIGHT_N-1:0] idle_bits;
    logic             hit;
    logic             found;
    logic [TAG_W-1:0] alloc_tag;
    logic             issue_rdy_c;
    logic             lk_vld_c;
    logic             rsp_ok;
    logic             wr_vld_q;
    logic [ID_W-1:0]  wr_id_q;
    logic [W-1:0]     wr_word_q;

    always_comb begin
        idle_bits = '0;
        hit       = 1'b0;
        for (int i = 0; i < IN_FLIGHT_N; i++) begin
            idle_bits[i] = (state[i] == ST_IDLE);
            if (state[i] != ST_IDLE && ent_id[i] == bus.issue_id) hit = 1'b1;
        end
    end

    rmw_long_latency_p_alloc #(.N(IN_FLIGHT_N), .TAG_W(TAG_W)) u_alloc (
        .idle  (idle_bits),
        .found (found),
        .tag   (alloc_tag)
    );

`ifdef RMW_LONG_LATENCY_P_COALESCE_EN
    logic [TAG_W-1:0] hit_idx;
    logic             merge;

    function automatic acc_t compose(input acc_t old_acc, input acc_t new_acc);
        acc_t r;
        r.is_mov = new_acc.is_mov ? 1'b1 : old_acc.is_mov;
        r.val    = new_acc.is_mov ? new_acc.val : old_acc.val + new_acc.val;
        return r;
    endfunction

    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < IN_FLIGHT_N; i++) begin
            if (state[i] != ST_IDLE && ent_id[i] == bus.issue_id) hit_idx = TAG_W'(i);
        end
    end
`endif

    // A hit never allocates: either it folds into a waiting entry or it stalls until the id drains.
    always_comb begin
        issue_rdy_c = 1'b0;
        lk_vld_c    = 1'b0;
`ifdef RMW_LONG_LATENCY_P_COALESCE_EN
        merge       = 1'b0;
`endif
        if (rst_n) begin
            if (bus.issue_op == OP_NOP) begin
                issue_rdy_c = 1'b1;
            end else if (hit) begin
`ifdef RMW_LONG_LATENCY_P_COALESCE_EN
                if (state[hit_idx] == ST_WAIT && !(bus.rsp_vld && bus.rsp_tag == hit_idx)) begin
                    issue_rdy_c = 1'b1;
                    merge       = bus.issue_vld;
                end
`endif
            end else if (found) begin
                lk_vld_c    = bus.issue_vld;
                issue_rdy_c = bus.lk_rdy;
            end
        end
    end

    assign rsp_ok = bus.rsp_vld && (state[bus.rsp_tag] == ST_WAIT);

    // WB lasts exactly one cycle, the cycle the registered write-back is visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IN_FLIGHT_N; i++) begin
                state[i]  <= ST_IDLE;
                ent_id[i] <= '0;
                acc[i]    <= '0;
            end
            wr_vld_q  <= 1'b0;
            wr_id_q   <= '0;
            wr_word_q <= '0;
        end else begin
            wr_vld_q <= 1'b0;
            for (int i = 0; i < IN_FLIGHT_N; i++) begin
                if (state[i] == ST_WB) state[i] <= ST_IDLE;
            end
            if (rsp_ok) begin
                state[bus.rsp_tag] <= ST_WB;
                wr_vld_q  <= 1'b1;
                wr_id_q   <= ent_id[bus.rsp_tag];
                wr_word_q <= acc[bus.rsp_tag].is_mov ? acc[bus.rsp_tag].val
                                                      : bus.rsp_word + acc[bus.rsp_tag].val;
            end
            if (lk_vld_c && bus.lk_rdy) begin
                state[alloc_tag]  <= ST_WAIT;
                ent_id[alloc_tag] <= bus.issue_id;
                acc[alloc_tag]    <= op_to_acc(bus.issue_op, bus.issue_imm);
            end
`ifdef RMW_LONG_LATENCY_P_COALESCE_EN
            if (merge) acc[hit_idx] <= compose(acc[hit_idx], op_to_acc(bus.issue_op, bus.issue_imm));
`endif
        end
    end

    // Responses to a tag that is not waiting (e.g. stale after a reset) are dropped.
    always @(posedge clk) begin
        if (rst_n && bus.rsp_vld)
            assert (state[bus.rsp_tag] == ST_WAIT)
            else $warning("response on tag %0d which has no lookup waiting", bus.rsp_tag);
    end

    assign bus.issue_rdy = issue_rdy_c;
    assign bus.lk_vld    = lk_vld_c;
    assign bus.lk_tag    = alloc_tag;
    assign bus.lk_id     = bus.issue_id;
    assign bus.wr_vld    = wr_vld_q;
    assign bus.wr_id     = wr_id_q;
    assign bus.wr_word   = wr_word_q;
    assign bus.busy      = ~&idle_bits;

endmodule

// File: tb/tb_rmw_long_latency_p.sv
// Directed bench for rmw_long_latency_p: vector table plus hand-written multi-cycle sequences.
module tb_rmw_long_latency_p;
    import rmw_long_latency_p_pkg::*;

    typedef struct {
        op_t         op;
        logic [15:0] id;
        logic [31:0] imm;
        logic [31:0] rsp;
        int          delay;
        logic [31:0] exp_word;
    } vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic [15:0] id;
        int          cyc;
    } pend_t;

    typedef struct {
        logic [15:0] id;
        logic [31:0] word;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   lk_count = 0;

    logic        auto_rsp = 1'b0;
    logic        a_vld, m_vld;
    logic [3:0]  a_tag, m_tag;
    logic [31:0] a_word, m_word;
    pend_t       pend_q[$];
    wr_t         wr_q[$];
    logic [31:0] tbl [logic [15:0]];

    int          stalls;
    logic [3:0]  got_tag;
    logic        got_lkv;
    logic [15:0] got_lkid;

    rmw_long_latency_p_if #(.W(32), .ID_W(16), .TAG_W(4)) bus ();

    rmw_long_latency_p #(.W(32), .ID_W(16), .IN_FLIGHT_N(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.rsp_vld  = auto_rsp ? a_vld  : m_vld;
    assign bus.rsp_tag  = auto_rsp ? a_tag  : m_tag;
    assign bus.rsp_word = auto_rsp ? a_word : m_word;

    // Table model: records accepted lookups and write-backs, and can answer lookups after 4 cycles.
    initial begin
        a_vld = 1'b0; a_tag = '0; a_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend_q.delete();
            end else begin
                if (bus.lk_vld && bus.lk_rdy) begin
                    pend_q.push_back('{tag: bus.lk_tag, id: bus.lk_id, cyc: cyc});
                    lk_count++;
                end
                if (bus.wr_vld) begin
                    wr_q.push_back('{id: bus.wr_id, word: bus.wr_word});
                    tbl[bus.wr_id] = bus.wr_word;
                end
            end
            @(posedge clk); #1;
            a_vld = 1'b0;
            if (auto_rsp && pend_q.size() > 0 && cyc - pend_q[0].cyc >= 4) begin
                a_vld  = 1'b1;
                a_tag  = pend_q[0].tag;
                a_word = tbl.exists(pend_q[0].id) ? tbl[pend_q[0].id] : 32'd0;
                void'(pend_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic vld, input op_t op, input logic [15:0] id, input logic [31:0] imm);
        bus.issue_vld = vld;
        bus.issue_op  = op;
        bus.issue_id  = id;
        bus.issue_imm = imm;
    endtask

    task automatic drive_rsp(input logic vld, input logic [3:0] tag, input logic [31:0] word);
        m_vld  = vld;
        m_tag  = tag;
        m_word = word;
    endtask

    task automatic next_drive();
        @(posedge clk); #1;
    endtask

    // Holds a command until accepted (bounded); returns the lookup fields seen on the accepting cycle.
    task automatic issue_cmd(input op_t op, input logic [15:0] id, input logic [31:0] imm, input int budget,
                             output int n, output logic [3:0] tag, output logic lkv, output logic [15:0] lkid);
        apply_stimulus(1'b1, op, id, imm);
        n = 0;
        @(negedge clk);
        while (!bus.issue_rdy && n < budget) begin
            @(negedge clk);
            n++;
        end
        tag  = bus.lk_tag;
        lkv  = bus.lk_vld;
        lkid = bus.lk_id;
        if (!bus.issue_rdy) check_output("issue accept timeout", 32'(bus.issue_rdy), 32'd1);
        next_drive();
        apply_stimulus(1'b0, OP_NOP, 16'd0, 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while ((bus.busy || pend_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("drain busy", 32'(bus.busy), 32'd0);
        next_drive();
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        issue_cmd(v.op, v.id, v.imm, 4, stalls, got_tag, got_lkv, got_lkid);
        check_output($sformatf("vec%0d lk_vld", idx), 32'(got_lkv), 32'd1);
        check_output($sformatf("vec%0d lk_tag", idx), 32'(got_tag), 32'd0);
        check_output($sformatf("vec%0d lk_id", idx), 32'(got_lkid), 32'(v.id));
        repeat (v.delay - 1) next_drive();
        @(negedge clk);
        check_output($sformatf("vec%0d busy waiting", idx), 32'(bus.busy), 32'd1);
        next_drive();
        drive_rsp(1'b1, 4'd0, v.rsp);
        next_drive();
        drive_rsp(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        check_output($sformatf("vec%0d wr_vld", idx), 32'(bus.wr_vld), 32'd1);
        check_output($sformatf("vec%0d wr_id", idx), 32'(bus.wr_id), 32'(v.id));
        check_output($sformatf("vec%0d wr_word", idx), bus.wr_word, v.exp_word);
        check_output($sformatf("vec%0d busy at wb", idx), 32'(bus.busy), 32'd1);
        next_drive();
        @(negedge clk);
        check_output($sformatf("vec%0d wr_vld after", idx), 32'(bus.wr_vld), 32'd0);
        check_output($sformatf("vec%0d busy after", idx), 32'(bus.busy), 32'd0);
        next_drive();
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{op: OP_ADDI, id: 16'd5,      imm: 32'd3,          rsp: 32'd10, delay: 20, exp_word: 32'd13};
        vecs[1] = '{op: OP_SUBI, id: 16'd6,      imm: 32'd1,          rsp: 32'd0,  delay: 3,  exp_word: 32'hFFFF_FFFF};
        vecs[2] = '{op: OP_MOVI, id: 16'd7,      imm: 32'd7,          rsp: 32'd99, delay: 5,  exp_word: 32'd7};
        vecs[3] = '{op: OP_ADDI, id: 16'hFFFF,   imm: 32'hFFFF_FFFF,  rsp: 32'd1,  delay: 2,  exp_word: 32'd0};
        vecs[4] = '{op: OP_SUBI, id: 16'd1,      imm: 32'd0,          rsp: 32'd5,  delay: 1,  exp_word: 32'd5};

        rst_n = 1'b0;
        bus.lk_rdy = 1'b1;
        drive_rsp(1'b0, 4'd0, 32'd0);
        apply_stimulus(1'b1, OP_ADDI, 16'd1, 32'd1);
        repeat (2) @(negedge clk);
        check_output("reset issue_rdy", 32'(bus.issue_rdy), 32'd0);
        check_output("reset lk_vld", 32'(bus.lk_vld), 32'd0);
        check_output("reset wr_vld", 32'(bus.wr_vld), 32'd0);
        check_output("reset busy", 32'(bus.busy), 32'd0);
        check_output("reset wr_id", 32'(bus.wr_id), 32'd0);
        check_output("reset wr_word", bus.wr_word, 32'd0);
        next_drive();
        rst_n = 1'b1;

        // NOP is accepted and dropped; a refused lookup leaves nothing allocated.
        apply_stimulus(1'b1, OP_NOP, 16'd3, 32'd3);
        @(negedge clk);
        check_output("nop issue_rdy", 32'(bus.issue_rdy), 32'd1);
        check_output("nop lk_vld", 32'(bus.lk_vld), 32'd0);
        next_drive();
        bus.lk_rdy = 1'b0;
        apply_stimulus(1'b1, OP_ADDI, 16'd3, 32'd3);
        @(negedge clk);
        check_output("lk_rdy low issue_rdy", 32'(bus.issue_rdy), 32'd0);
        check_output("lk_rdy low lk_vld", 32'(bus.lk_vld), 32'd1);
        next_drive();
        bus.lk_rdy = 1'b1;
        apply_stimulus(1'b0, OP_NOP, 16'd0, 32'd0);
        @(negedge clk);
        check_output("no alloc busy", 32'(bus.busy), 32'd0);
        next_drive();

        for (int i = 0; i < 5; i++) run_vector(vecs[i], i);

        // Three commands on id 9 before the first lookup returns.
        $display("[TB] same-id sequence");
        tbl[16'd9] = 32'd100;
        wr_q.delete();
        pend_q.delete();
        lk_count = 0;
        auto_rsp = 1'b1;
        issue_cmd(OP_ADDI, 16'd9, 32'd2, 40, stalls, got_tag, got_lkv, got_lkid);
        check_output("same-id cmd1 lk_vld", 32'(got_lkv), 32'd1);
        issue_cmd(OP_SUBI, 16'd9, 32'd5, 40, stalls, got_tag, got_lkv, got_lkid);
`ifdef RMW_LONG_LATENCY_P_COALESCE_EN
        check_output("same-id cmd2 lk_vld", 32'(got_lkv), 32'd0);
        check_output("same-id cmd2 stalls", 32'(stalls), 32'd0);
`else
        check_output("same-id cmd2 lk_vld", 32'(got_lkv), 32'd1);
        check_output("same-id cmd2 tag", 32'(got_tag), 32'd0);
`endif
        issue_cmd(OP_ADDI, 16'd9, 32'd1, 40, stalls, got_tag, got_lkv, got_lkid);
        wait_idle(100);
        auto_rsp = 1'b0;
`ifdef RMW_LONG_LATENCY_P_COALESCE_EN
        check_output("same-id lookups", 32'(lk_count), 32'd1);
        check_output("same-id wb count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() >= 1) check_output("same-id wb0", wr_q[0].word, 32'd98);
`else
        check_output("same-id lookups", 32'(lk_count), 32'd3);
        check_output("same-id wb count", 32'(wr_q.size()), 32'd3);
        if (wr_q.size() >= 3) begin
            check_output("same-id wb0", wr_q[0].word, 32'd102);
            check_output("same-id wb1", wr_q[1].word, 32'd97);
            check_output("same-id wb2", wr_q[2].word, 32'd98);
        end
`endif

        // Fill every tag, stall a 17th, then answer in reverse order.
        $display("[TB] full-table sequence");
        for (int i = 0; i < 16; i++) begin
            issue_cmd(OP_ADDI, 16'(100 + i), 32'(i), 4, stalls, got_tag, got_lkv, got_lkid);
            check_output($sformatf("fill tag %0d", i), 32'(got_tag), 32'(i));
        end
        wr_q.delete();
        apply_stimulus(1'b1, OP_ADDI, 16'd200, 32'd7);
        @(negedge clk);
        check_output("full issue_rdy", 32'(bus.issue_rdy), 32'd0);
        check_output("full lk_vld", 32'(bus.lk_vld), 32'd0);
        next_drive();
        for (int k = 0; k < 16; k++) begin
            drive_rsp(1'b1, 4'(15 - k), 32'd1000);
            @(negedge clk);
            if (k < 2) begin
                check_output($sformatf("17th stall k%0d", k), 32'(bus.issue_rdy), 32'd0);
            end else if (k == 2) begin
                check_output("17th issue_rdy", 32'(bus.issue_rdy), 32'd1);
                check_output("17th lk_tag", 32'(bus.lk_tag), 32'd15);
            end
            next_drive();
            if (k == 2) apply_stimulus(1'b0, OP_NOP, 16'd0, 32'd0);
        end
        drive_rsp(1'b1, 4'd15, 32'd2000);
        next_drive();
        drive_rsp(1'b0, 4'd0, 32'd0);
        wait_idle(20);
        check_output("reverse wb count", 32'(wr_q.size()), 32'd17);
        for (int k = 0; k < 16 && k < wr_q.size(); k++) begin
            check_output($sformatf("reverse wb%0d id", k), 32'(wr_q[k].id), 32'(115 - k));
            check_output($sformatf("reverse wb%0d word", k), wr_q[k].word, 32'(1015 - k));
        end
        if (wr_q.size() >= 17) begin
            check_output("17th wb id", 32'(wr_q[16].id), 32'd200);
            check_output("17th wb word", wr_q[16].word, 32'd2007);
        end

        // Same-id command arriving with the response to its entry.
        $display("[TB] hit-while-responding sequence");
        for (int i = 0; i < 4; i++) begin
            issue_cmd(OP_ADDI, 16'(300 + i), 32'd5, 4, stalls, got_tag, got_lkv, got_lkid);
        end
        drive_rsp(1'b1, 4'd3, 32'd50);
        apply_stimulus(1'b1, OP_ADDI, 16'd303, 32'd1);
        @(negedge clk);
        check_output("rsp-hit t issue_rdy", 32'(bus.issue_rdy), 32'd0);
        next_drive();
        drive_rsp(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        check_output("rsp-hit t+1 issue_rdy", 32'(bus.issue_rdy), 32'd0);
        check_output("rsp-hit wr_id", 32'(bus.wr_id), 32'd303);
        check_output("rsp-hit wr_word", bus.wr_word, 32'd55);
        next_drive();
        @(negedge clk);
        check_output("rsp-hit t+2 issue_rdy", 32'(bus.issue_rdy), 32'd1);
        check_output("rsp-hit t+2 lk_vld", 32'(bus.lk_vld), 32'd1);
        check_output("rsp-hit t+2 lk_tag", 32'(bus.lk_tag), 32'd3);
        next_drive();
        apply_stimulus(1'b0, OP_NOP, 16'd0, 32'd0);
        drive_rsp(1'b1, 4'd3, 32'd55);
        next_drive();
        drive_rsp(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        check_output("rsp-hit second wr_word", bus.wr_word, 32'd56);
        next_drive();
        for (int i = 0; i < 3; i++) begin
            drive_rsp(1'b1, 4'(i), 32'd0);
            next_drive();
        end
        drive_rsp(1'b0, 4'd0, 32'd0);
        wait_idle(10);

        // Reset with lookups outstanding, followed by stale responses.
        $display("[TB] mid-operation reset sequence");
        for (int i = 0; i < 4; i++) begin
            issue_cmd(OP_ADDI, 16'(400 + i), 32'd1, 4, stalls, got_tag, got_lkv, got_lkid);
        end
        wr_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        check_output("mid reset busy", 32'(bus.busy), 32'd0);
        check_output("mid reset issue_rdy", 32'(bus.issue_rdy), 32'd0);
        next_drive();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_rsp(1'b1, 4'(k), 32'd77);
            next_drive();
        end
        drive_rsp(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        check_output("stale wb count", 32'(wr_q.size()), 32'd0);
        check_output("stale busy", 32'(bus.busy), 32'd0);
        next_drive();
        issue_cmd(OP_ADDI, 16'd500, 32'd1, 4, stalls, got_tag, got_lkv, got_lkid);
        check_output("post-reset tag", 32'(got_tag), 32'd0);
        drive_rsp(1'b1, 4'd0, 32'd9);
        next_drive();
        drive_rsp(1'b0, 4'd0, 32'd0);
        @(negedge clk);
        check_output("post-reset wr_word", bus.wr_word, 32'd10);
        next_drive();
        wait_idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
